change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Downstream of the change calculator. Takes its one-cycle change requests (quarter_out count,
//  dollar_out) and drives the physical coin hoppers one coin at a time.
//  Each coin is ejected with a timed pulse and confirmed by the hopper exit sensor.
//  A small request FIFO absorbs back-to-back requests. A missing coin raises a sticky fault.
// PARAMETERS
//  PULSE_CYCLES  4    eject pulse width in clk cycles (>=1)
//  ACK_TIMEOUT   255  max cycles to wait for coin_sensed after a pulse ends (>=1)
//  FIFO_DEPTH    2    request FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1  system clock, all state on rising edge
//  reset          in   1  asynchronous, active-low reset
//  quarter_out    in   3  quarters of change requested (from change calculator)
//  dollar_out     in   1  one dollar coin requested (from change calculator)
//  coin_sensed    in   1  hopper exit sensor, 1-cycle pulse per coin (either hopper)
//  quarter_eject  out  1  quarter hopper eject pulse
//  dollar_eject   out  1  dollar hopper eject pulse
//  busy           out  1  FSM not IDLE, or FIFO not empty
//  fault          out  1  sticky: coin not sensed within ACK_TIMEOUT
//  overflow       out  1  sticky: request dropped, FIFO full
// BEHAVIOUR
//  - Reset (reset==0, async): all outputs 0, FIFO empty, FSM=IDLE, counters 0.
//  - Request: any cycle with (quarter_out!=0 || dollar_out) pushes one entry {dollar_out,quarter_out}.
//    Each such cycle is a distinct request. Level-held inputs push once per cycle.
//  - Full FIFO: the push is dropped and overflow is set. Exception: a push and a pop in the same
//    cycle on a full FIFO is accepted and overflow stays 0.
//  - FSM states: IDLE, LOAD, D_PULSE, D_WAIT, Q_PULSE, Q_WAIT, FAULT.
//    IDLE -> LOAD when FIFO is not empty.
//    LOAD pops the entry into dcnt (1b) and qcnt (3b).
//    After LOAD: dcnt -> D_PULSE, else qcnt -> Q_PULSE.
//    Dollar is always dispensed before quarters.
//  - *_PULSE: matching eject=1 (registered) for exactly PULSE_CYCLES cycles, then -> *_WAIT.
//  - *_WAIT: on coin_sensed, decrement the count. Next state: D_PULSE if dcnt!=0,
//    else Q_PULSE if qcnt!=0, else IDLE (or LOAD if the FIFO is not empty).
//  - coin_sensed during *_PULSE is latched. *_WAIT then exits on its first cycle.
//    At most one latched sense per coin; extra pulses are ignored.
//  - coin_sensed in IDLE, LOAD or FAULT: ignored.
//  - Timeout: ACK_TIMEOUT cycles in *_WAIT with no sense -> FAULT.
//    FAULT: fault=1, both ejects 0, stays until reset. FIFO still accepts and overflows.
//  - Latency: request in cycle t -> LOAD in cycle t+1 -> eject first high in cycle t+2.
//    Between coins: one sense cycle, then the next pulse starts on the following cycle.
//  - quarter_eject and dollar_eject are never both 1.
//  - Reset mid-pulse drops both ejects immediately (asynchronously).
// CONFIGURATION
//  CHANGE_TOTAL_EN defined:
//    adds output total_dispensed [7:0]: count of confirmed coins in quarter units
//    (dollar = +4, quarter = +1). Saturates at 255. Cleared by reset.
//  CHANGE_TOTAL_EN undefined: the port and its counter do not exist.
//    All other behaviour is identical.
// TESTING
//  1. quarter_out=3 for 1 cycle, sense 2 cycles after each pulse ends -> 3 quarter pulses of 4 cycles,
//     dollar_eject never high, busy drops after the third sense.
//  2. dollar_out=1 with quarter_out=2 in the same cycle -> 1 dollar pulse, then 2 quarter pulses, in order.
//  3. Three requests on consecutive cycles while busy (FIFO_DEPTH=2) -> third dropped, overflow=1,
//     first two fully served.
//  4. quarter_out=1, no sense -> fault=1 exactly ACK_TIMEOUT cycles after the pulse ends.
//     Ejects stay 0 afterwards until reset.
//  5. Assert reset during D_PULSE -> dollar_eject=0 at once. After release, all outputs 0 and FIFO empty.
//  6. CHANGE_TOTAL_EN: dispense 64 dollars -> total_dispensed saturates at 255, never wraps.

Source files
------------

// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - change request and coin hopper signals
interface change_dispenser_if;
  logic [2:0] quarter_out;
  logic       dollar_out;
  logic       coin_sensed;
  logic       quarter_eject;
  logic       dollar_eject;

  modport master (
    output quarter_out, dollar_out, coin_sensed,
    input  quarter_eject, dollar_eject
  );
  modport slave (
    input  quarter_out, dollar_out, coin_sensed,
    output quarter_eject, dollar_eject
  );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - request FIFO plus one-coin-at-a-time eject/sense FSM
// Optional CHANGE_TOTAL_EN adds total_dispensed (confirmed coins in quarter units).
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 255,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic clk,
  input  logic reset,
  change_dispenser_if.slave bus,
  output logic busy,
  output logic fault,
  output logic overflow
`ifdef CHANGE_TOTAL_EN
  ,
  output logic [7:0] total_dispensed
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, D_PULSE, D_WAIT, Q_PULSE, Q_WAIT, FAULT} state_t;

  localparam int CMAX = (PULSE_CYCLES > ACK_TIMEOUT) ? PULSE_CYCLES : ACK_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  state_t        state_q, state_d;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic          dcnt_q, dcnt_d;
  logic [2:0]    qcnt_q, qcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sensed_q, sensed_d;
  logic          qej_q, qej_d, dej_q, dej_d;
  logic          fault_q, fault_d, overflow_q, overflow_d;
  logic          req, push, pop, empty, full, pending;
  logic          in_pulse, in_wait, accept, dcnt_left;
  logic [2:0]    qcnt_left;
  logic [3:0]    head;

  assign req       = (bus.quarter_out != 3'd0) || bus.dollar_out;
  assign empty     = (count_q == '0);
  assign full      = (count_q == FIFO_FULL);
  assign pop       = (state_q == LOAD);
  assign push      = req && (!full || pop);
  // A push landing this cycle counts as pending so a request reaches LOAD one cycle later.
  assign pending   = !empty || push;
  assign head      = mem_q[rd_q];
  assign in_pulse  = (state_q == D_PULSE) || (state_q == Q_PULSE);
  assign in_wait   = (state_q == D_WAIT) || (state_q == Q_WAIT);
  assign accept    = in_wait && (bus.coin_sensed || sensed_q);
  assign dcnt_left = (state_q == D_WAIT) ? 1'b0 : dcnt_q;
  assign qcnt_left = (state_q == Q_WAIT) ? qcnt_q - 3'd1 : qcnt_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {bus.dollar_out, bus.quarter_out};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_ONE;
      if (pop)  rd_q <= rd_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      dcnt_q     <= 1'b0;
      qcnt_q     <= 3'd0;
      cnt_q      <= '0;
      sensed_q   <= 1'b0;
      qej_q      <= 1'b0;
      dej_q      <= 1'b0;
      fault_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      qcnt_q     <= qcnt_d;
      cnt_q      <= cnt_d;
      sensed_q   <= sensed_d;
      qej_q      <= qej_d;
      dej_q      <= dej_d;
      fault_q    <= fault_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    qcnt_d  = qcnt_q;
    case (state_q)
      IDLE: if (pending) state_d = LOAD;
      LOAD: begin
        dcnt_d  = head[3];
        qcnt_d  = head[2:0];
        state_d = head[3] ? D_PULSE : Q_PULSE;
      end
      D_PULSE: if (cnt_q == PULSE_LAST) state_d = D_WAIT;
      Q_PULSE: if (cnt_q == PULSE_LAST) state_d = Q_WAIT;
      D_WAIT, Q_WAIT: begin
        if (accept) begin
          dcnt_d = dcnt_left;
          qcnt_d = qcnt_left;
          if (dcnt_left)              state_d = D_PULSE;
          else if (qcnt_left != 3'd0) state_d = Q_PULSE;
          else if (pending)           state_d = LOAD;
          else                        state_d = IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = FAULT;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    qej_d      = (state_d == Q_PULSE);
    dej_d      = (state_d == D_PULSE);
    fault_d    = (state_d == FAULT);
    overflow_d = overflow_q || (req && full && !pop);
    // One latched sense per coin; it is consumed by the WAIT state that follows.
    sensed_d   = in_pulse && (sensed_q || bus.coin_sensed);
    cnt_d      = ((state_d == state_q) && (in_pulse || in_wait)) ? cnt_q + CNT_ONE : '0;
  end

  assign bus.quarter_eject = qej_q;
  assign bus.dollar_eject  = dej_q;
  assign fault             = fault_q;
  assign overflow          = overflow_q;
  assign busy              = (state_q != IDLE) || !empty;

`ifdef CHANGE_TOTAL_EN
  logic [7:0] total_q, total_d;
  logic [8:0] total_sum;

  assign total_sum = {1'b0, total_q} + ((state_q == D_WAIT) ? 9'd4 : 9'd1);

  always_comb begin
    total_d = total_q;
    if (accept) total_d = total_sum[8] ? 8'hFF : total_sum[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) total_q <= 8'd0;
    else        total_q <= total_d;
  end

  assign total_dispensed = total_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - self-checking bench for change_dispenser
// Hopper responder plus transaction-level model of expected coin sequences.
module tb_change_dispenser;
  localparam int P  = 4;
  localparam int AT = 255;

  logic clk = 1'b0;
  logic reset;
  logic busy, fault, overflow;
`ifdef CHANGE_TOTAL_EN
  logic [7:0] total;
`endif

  change_dispenser_if bus();

  change_dispenser #(.PULSE_CYCLES(P), .ACK_TIMEOUT(AT), .FIFO_DEPTH(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .fault(fault),
    .overflow(overflow)
`ifdef CHANGE_TOTAL_EN
    ,
    .total_dispensed(total)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {bit is_d; int start; int width;} coin_t;
  coin_t coins[$];
  int    senses[$];
  int    both_seen = 0;
  bit    auto_sense = 0;
  bit    dbl = 0;
  int    sense_off = P + 2;
  int    cd1 = 0, cd2 = 0;
  bit    prev_on = 0, run_d = 0;
  int    run_start = 0;

  // Hopper: senses a coin sense_off cycles after its pulse rises; records every pulse.
  always @(negedge clk) begin
    bit s;
    bit on;
    s = 0;
    if (cd1 > 0) begin cd1--; if (cd1 == 0) s = 1; end
    if (cd2 > 0) begin cd2--; if (cd2 == 0) s = 1; end
    if (s && auto_sense) senses.push_back(cyc);
    bus.coin_sensed = s && auto_sense;
    if (bus.quarter_eject && bus.dollar_eject) both_seen++;
    on = bus.quarter_eject || bus.dollar_eject;
    if (on && !prev_on) begin
      run_start = cyc;
      run_d     = bus.dollar_eject;
      cd1       = sense_off;
      cd2       = dbl ? P : 0;
    end
    if (!on && prev_on) coins.push_back('{run_d, run_start, cyc - run_start});
    prev_on = on;
  end

  task automatic do_reset();
    bus.quarter_out = 3'd0;
    bus.dollar_out  = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [2:0] q, input logic d, output int at);
    @(posedge clk);
    #1;
    bus.quarter_out = q;
    bus.dollar_out  = d;
    at = cyc;
  endtask

  task automatic clear_req();
    @(posedge clk);
    #1;
    bus.quarter_out = 3'd0;
    bus.dollar_out  = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit timed_out, output int at);
    timed_out = 1;
    at = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) begin
        timed_out = 0;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.quarter_eject, bus.dollar_eject, busy, fault, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%b expected 00000",
               {bus.quarter_eject, bus.dollar_eject, busy, fault, overflow});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.quarter_eject, bus.dollar_eject, busy, fault, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_release: outputs=%b expected 00000",
               {bus.quarter_eject, bus.dollar_eject, busy, fault, overflow});
    end
  endtask

  task automatic test_quarters();
    int t, idle_at, base, sbase;
    bit to;
    base = coins.size(); sbase = senses.size();
    auto_sense = 1; dbl = 0; sense_off = P + 2;
    send_req(3'd3, 1'b0, t);
    clear_req();
    wait_idle(500, to, idle_at);
    checks++;
    if (to) begin errors++; $display("FAIL quarters_idle: busy never dropped, expected idle"); end
    checks++;
    if (coins.size() - base != 3) begin
      errors++;
      $display("FAIL quarters_count: got %0d pulses expected 3", coins.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (coins[base+i].is_d !== 1'b0 || coins[base+i].width != P) begin
          errors++;
          $display("FAIL quarters_pulse%0d: is_d=%0d width=%0d expected 0/%0d",
                   i, coins[base+i].is_d, coins[base+i].width, P);
        end
      end
      checks++;
      if (coins[base].start != t + 2) begin
        errors++;
        $display("FAIL quarters_latency: first eject cycle %0d expected %0d", coins[base].start, t + 2);
      end
      if (senses.size() - sbase == 3) begin
        for (int i = 1; i < 3; i++) begin
          checks++;
          if (coins[base+i].start != senses[sbase+i-1] + 1) begin
            errors++;
            $display("FAIL quarters_gap%0d: pulse start %0d expected %0d",
                     i, coins[base+i].start, senses[sbase+i-1] + 1);
          end
        end
        checks++;
        if (idle_at != senses[sbase+2] + 1) begin
          errors++;
          $display("FAIL quarters_busy_drop: idle cycle %0d expected %0d", idle_at, senses[sbase+2] + 1);
        end
      end
    end
  endtask

  task automatic test_dollar_first();
    int t, idle_at, base;
    bit to;
    bit exp_d[3];
    exp_d = '{1'b1, 1'b0, 1'b0};
    base = coins.size();
    sense_off = P + 1;
    send_req(3'd2, 1'b1, t);
    clear_req();
    wait_idle(500, to, idle_at);
    checks++;
    if (to || coins.size() - base != 3) begin
      errors++;
      $display("FAIL dq_count: got %0d pulses (timeout=%0d) expected 3", coins.size() - base, to);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (coins[base+i].is_d !== exp_d[i] || coins[base+i].width != P) begin
          errors++;
          $display("FAIL dq_order%0d: is_d=%0d width=%0d expected %0d/%0d",
                   i, coins[base+i].is_d, coins[base+i].width, exp_d[i], P);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int t, idle_at, base;
    bit to, seen;
    bit exp_d[7];
    exp_d = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    base = coins.size();
    sense_off = P + 2;
    send_req(3'd2, 1'b0, t);
    clear_req();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.quarter_eject;
    end
    send_req(3'd1, 1'b1, t);
    send_req(3'd3, 1'b0, t);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_no_overflow: overflow=%b expected 0", overflow);
    end
    send_req(3'd1, 1'b0, t);
    clear_req();
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL b2b_overflow: overflow=%b expected 1", overflow);
    end
    wait_idle(1000, to, idle_at);
    checks++;
    if (to || coins.size() - base != 7) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses (timeout=%0d) expected 7", coins.size() - base, to);
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (coins[base+i].is_d !== exp_d[i]) begin
          errors++;
          $display("FAIL b2b_order%0d: is_d=%0d expected %0d", i, coins[base+i].is_d, exp_d[i]);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL b2b_sticky: overflow=%b expected 1", overflow);
    end
  endtask

  task automatic test_random();
    bit exp_ovf;
    bit exp_d[$];
    int base, n, t, idle_at, bad;
    bit to;
    logic [2:0] q;
    logic d;
    do_reset();
    exp_ovf = 0;
    for (int b = 0; b < 30; b++) begin
      n = $urandom_range(1, 4);
      sense_off = $urandom_range(1, P + 3);
      dbl = (sense_off < P) ? 1'($urandom_range(0, 1)) : 1'b0;
      base = coins.size();
      exp_d.delete();
      for (int i = 0; i < n; i++) begin
        q = 3'($urandom_range(0, 7));
        d = 1'($urandom_range(0, 1));
        if (q == 3'd0 && !d) q = 3'd1;
        send_req(q, d, t);
        // From idle, the first request is popped at once and two more fit in the FIFO.
        if (i < 3) begin
          if (d) exp_d.push_back(1'b1);
          for (int j = 0; j < int'(q); j++) exp_d.push_back(1'b0);
        end
      end
      clear_req();
      if (n > 3) exp_ovf = 1;
      wait_idle(3000, to, idle_at);
      checks++;
      if (to) begin errors++; $display("FAIL rand%0d_idle: busy never dropped", b); end
      checks++;
      if (overflow !== exp_ovf) begin
        errors++; $display("FAIL rand%0d_overflow: overflow=%b expected %b", b, overflow, exp_ovf);
      end
      checks++;
      if (coins.size() - base != exp_d.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d pulses expected %0d", b, coins.size() - base, exp_d.size());
      end else begin
        bad = 0;
        for (int i = 0; i < exp_d.size(); i++)
          if (coins[base+i].is_d !== exp_d[i] || coins[base+i].width != P) bad++;
        checks++;
        if (bad != 0) begin
          errors++; $display("FAIL rand%0d_sequence: %0d wrong pulses expected 0", b, bad);
        end
      end
    end
    dbl = 0;
    checks++;
    if (both_seen != 0) begin
      errors++; $display("FAIL both_ejects: seen %0d cycles expected 0", both_seen);
    end
  endtask

  task automatic test_timeout();
    int t, t2, start, fcyc, highs;
    bit found;
    do_reset();
    auto_sense = 0;
    send_req(3'd1, 1'b0, t);
    clear_req();
    start = t + 2;
    found = 0;
    fcyc = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (fault === 1'b1) begin found = 1; fcyc = cyc; end
    end
    checks++;
    if (!found || fcyc != start + P + AT) begin
      errors++;
      $display("FAIL timeout_cycle: fault at %0d (found=%0d) expected %0d", fcyc, found, start + P + AT);
    end
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.quarter_eject || bus.dollar_eject) highs++;
    end
    checks++;
    if (highs != 0 || fault !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fault_hold: eject_cycles=%0d fault=%b busy=%b expected 0/1/1", highs, fault, busy);
    end
    send_req(3'd1, 1'b0, t2);
    send_req(3'd2, 1'b0, t2);
    clear_req();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL fault_fifo_fill: overflow=%b expected 0", overflow);
    end
    send_req(3'd3, 1'b0, t2);
    clear_req();
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL fault_fifo_overflow: overflow=%b expected 1", overflow);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int t;
    bit seen;
    do_reset();
    auto_sense = 1; sense_off = P + 2;
    send_req(3'd0, 1'b1, t);
    clear_req();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.dollar_eject;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_pulse_start: dollar_eject never rose"); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.quarter_eject, bus.dollar_eject, busy, fault, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL mid_pulse_async: outputs=%b expected 00000",
               {bus.quarter_eject, bus.dollar_eject, busy, fault, overflow});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.quarter_eject, bus.dollar_eject, busy, fault, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL mid_pulse_after: outputs=%b expected 00000",
               {bus.quarter_eject, bus.dollar_eject, busy, fault, overflow});
    end
  endtask

`ifdef CHANGE_TOTAL_EN
  task automatic test_total();
    int t, idle_at, expv;
    bit to;
    do_reset();
    auto_sense = 1; dbl = 0; sense_off = P + 1;
    checks++;
    if (total !== 8'd0) begin errors++; $display("FAIL total_reset: total=%0d expected 0", total); end
    for (int k = 1; k <= 64; k++) begin
      send_req(3'd0, 1'b1, t);
      clear_req();
      wait_idle(200, to, idle_at);
      expv = (4 * k > 255) ? 255 : 4 * k;
      checks++;
      if (to || total !== 8'(expv)) begin
        errors++;
        $display("FAIL total_%0d: total=%0d (timeout=%0d) expected %0d", k, total, to, expv);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    bus.quarter_out = 3'd0;
    bus.dollar_out  = 1'b0;
    test_reset();
    test_quarters();
    test_dollar_first();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid_pulse();
`ifdef CHANGE_TOTAL_EN
    test_total();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
